// File: rtl/cart_mapper.sv
// Cartridge mapper: CPU-programmable PRG/CHR banking for NROM, UxROM, CNROM and MMC1.
// Address outputs are combinational from the buses and the bank registers.
module cart_mapper #(
    parameter int unsigned PRG_AW = 17,
    parameter int unsigned CHR_AW = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [1:0]        mapper_id,
    input  logic              prg_size,
    input  logic              mirror_v,
    input  logic [15:0]       prga,
    input  logic [7:0]        prgd,
    input  logic              prgw,
    input  logic [13:0]       chra,
    output logic [PRG_AW-1:0] prg_address,
    output logic [CHR_AW-1:0] chr_address,
    output logic              prg_ram_sel,
    output logic              vram_a10
);

    typedef enum logic [1:0] {
        MapNrom  = 2'd0,
        MapUxrom = 2'd1,
        MapCnrom = 2'd2,
        MapMmc1  = 2'd3
    } map_e;

    map_e       map;
    logic       wr_acc;
    logic       mmc_wr;
    logic [4:0] shift_in;
    logic       unused_chra;

    logic [7:0] prg_bank_q, prg_bank_d;
    logic [7:0] chr_bank_q, chr_bank_d;
    logic [4:0] shift_q, shift_d;
    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q, prg_d;
    logic       last_wr_q, last_wr_d;

    assign map         = map_e'(mapper_id);
    assign unused_chra = chra[13];
    assign wr_acc      = ce & prgw & prga[15];
    // MMC1 ignores a write that directly follows another CPU write cycle.
    assign mmc_wr      = wr_acc & (map == MapMmc1) & ~last_wr_q;
    assign shift_in    = {prgd[0], shift_q[4:1]};

    always_comb begin
        prg_bank_d = prg_bank_q;
        chr_bank_d = chr_bank_q;
        shift_d    = shift_q;
        control_d  = control_q;
        chr0_d     = chr0_q;
        chr1_d     = chr1_q;
        prg_d      = prg_q;
        last_wr_d  = last_wr_q;

        if (ce) begin
            last_wr_d = prgw;
        end
        if (wr_acc && map == MapUxrom) begin
            prg_bank_d = prgd;
        end
        if (wr_acc && map == MapCnrom) begin
            chr_bank_d = prgd;
        end

        if (mmc_wr) begin
            if (prgd[7]) begin
                shift_d   = 5'b10000;
                control_d = control_q | 5'h0C;
            end else if (!shift_q[0]) begin
                shift_d = shift_in;
            end else begin
                // Marker bit reached bit 0: this is the fifth bit of the value.
                shift_d = 5'b10000;
                unique case (prga[14:13])
                    2'd0:    control_d = shift_in;
                    2'd1:    chr0_d    = shift_in;
                    2'd2:    chr1_d    = shift_in;
                    default: prg_d     = shift_in;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prg_bank_q <= 8'd0;
            chr_bank_q <= 8'd0;
            shift_q    <= 5'b10000;
            control_q  <= 5'h0C;
            chr0_q     <= 5'd0;
            chr1_q     <= 5'd0;
            prg_q      <= 5'd0;
            last_wr_q  <= 1'b0;
        end else begin
            prg_bank_q <= prg_bank_d;
            chr_bank_q <= chr_bank_d;
            shift_q    <= shift_d;
            control_q  <= control_d;
            chr0_q     <= chr0_d;
            chr1_q     <= chr1_d;
            prg_q      <= prg_d;
            last_wr_q  <= last_wr_d;
        end
    end

    // Bank numbers are built wide and truncated, so banks wrap modulo the ROM size.
    always_comb begin
        prg_address = PRG_AW'({18'd0, prga[13:0]});
        chr_address = CHR_AW'({19'd0, chra[12:0]});
        vram_a10    = mirror_v ? chra[10] : chra[11];

        unique case (map)
            MapNrom: begin
                prg_address = prg_size ? PRG_AW'({17'd0, prga[14:0]})
                                       : PRG_AW'({18'd0, prga[13:0]});
            end
            MapUxrom: begin
                prg_address = prga[14] ? PRG_AW'({18'h3FFFF, prga[13:0]})
                                       : PRG_AW'({18'(prg_bank_q), prga[13:0]});
            end
            MapCnrom: begin
                prg_address = PRG_AW'({17'd0, prga[14:0]});
                chr_address = CHR_AW'({19'(chr_bank_q), chra[12:0]});
            end
            default: begin
                unique case (control_q[3:2])
                    2'b10: begin
                        prg_address = PRG_AW'({18'(prga[14] ? prg_q[3:0] : 4'd0), prga[13:0]});
                    end
                    2'b11: begin
                        prg_address = prga[14] ? PRG_AW'({18'h3FFFF, prga[13:0]})
                                               : PRG_AW'({18'(prg_q[3:0]), prga[13:0]});
                    end
                    default: begin
                        prg_address = PRG_AW'({17'(prg_q[3:1]), prga[14:0]});
                    end
                endcase

                chr_address = control_q[4]
                    ? CHR_AW'({20'(chra[12] ? chr1_q : chr0_q), chra[11:0]})
                    : CHR_AW'({19'(chr0_q[4:1]), chra[12:0]});

                unique case (control_q[1:0])
                    2'd0:    vram_a10 = 1'b0;
                    2'd1:    vram_a10 = 1'b1;
                    2'd2:    vram_a10 = chra[10];
                    default: vram_a10 = chra[11];
                endcase
            end
        endcase
    end

    assign prg_ram_sel = (prga[15:13] == 3'b011) & ((map != MapMmc1) | ~prg_q[4]);

endmodule

// File: tb/tb_cart_mapper.sv
// Bench for cart_mapper: arithmetic reference model checked every cycle on the falling edge,
// plus hand-computed literal expectations at key points.
module tb_cart_mapper;

    localparam int unsigned PRG_AW = 17;
    localparam int unsigned CHR_AW = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              ce;
    logic [1:0]        mapper_id;
    logic              prg_size;
    logic              mirror_v;
    logic [15:0]       prga;
    logic [7:0]        prgd;
    logic              prgw;
    logic [13:0]       chra;
    logic [PRG_AW-1:0] prg_address;
    logic [CHR_AW-1:0] chr_address;
    logic              prg_ram_sel;
    logic              vram_a10;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;
    int n_cyc   = 0;

    // Reference state: MMC1 shift register kept as a bit count plus accumulated value.
    int m_prg_bank, m_chr_bank, m_ctrl, m_chr0, m_chr1, m_prg, m_sh_n, m_sh_v;
    bit m_last;

    cart_mapper #(
        .PRG_AW(PRG_AW),
        .CHR_AW(CHR_AW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ce          (ce),
        .mapper_id   (mapper_id),
        .prg_size    (prg_size),
        .mirror_v    (mirror_v),
        .prga        (prga),
        .prgd        (prgd),
        .prgw        (prgw),
        .chra        (chra),
        .prg_address (prg_address),
        .chr_address (chr_address),
        .prg_ram_sel (prg_ram_sel),
        .vram_a10    (vram_a10)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_prg_bank = 0; m_chr_bank = 0; m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_sh_n = 0; m_sh_v = 0; m_last = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        if (!reset_n) return;
        acc = ce && prgw && (prga >= 16'h8000);
        if (mapper_id == 2'd1 && acc) m_prg_bank = int'(prgd);
        if (mapper_id == 2'd2 && acc) m_chr_bank = int'(prgd);
        if (mapper_id == 2'd3 && acc && !m_last) begin
            if (prgd[7]) begin
                m_sh_n = 0; m_sh_v = 0; m_ctrl = m_ctrl | 12;
            end else begin
                m_sh_v = m_sh_v | (int'(prgd[0]) << m_sh_n);
                if (m_sh_n == 4) begin
                    case (prga[14:13])
                        2'd0:    m_ctrl = m_sh_v;
                        2'd1:    m_chr0 = m_sh_v;
                        2'd2:    m_chr1 = m_sh_v;
                        default: m_prg  = m_sh_v;
                    endcase
                    m_sh_n = 0; m_sh_v = 0;
                end else begin
                    m_sh_n++;
                end
            end
        end
        if (ce) m_last = prgw;
    endtask

    function automatic longint exp_prg(input logic [15:0] a);
        longint off  = longint'(a) & 'h3FFF;
        longint o32  = longint'(a) & 'h7FFF;
        longint last = (longint'(1) << (PRG_AW - 14)) - 1;
        longint r;
        bit     hi   = (a >= 16'hC000);
        case (mapper_id)
            2'd0: r = prg_size ? o32 : off;
            2'd1: r = hi ? last * 16384 + off : longint'(m_prg_bank) * 16384 + off;
            2'd2: r = o32;
            default: begin
                case ((m_ctrl >> 2) & 3)
                    0, 1: r = longint'((m_prg >> 1) & 7) * 32768 + o32;
                    2:    r = hi ? longint'(m_prg & 15) * 16384 + off : off;
                    default: r = hi ? last * 16384 + off : longint'(m_prg & 15) * 16384 + off;
                endcase
            end
        endcase
        return r & ((longint'(1) << PRG_AW) - 1);
    endfunction

    function automatic longint exp_chr(input logic [13:0] ch);
        longint low = longint'(ch) & 'h1FFF;
        longint r;
        case (mapper_id)
            2'd2: r = longint'(m_chr_bank) * 8192 + low;
            2'd3: begin
                if ((m_ctrl & 16) != 0)
                    r = longint'(((longint'(ch) & 'h1000) != 0) ? m_chr1 : m_chr0) * 4096
                        + (longint'(ch) & 'hFFF);
                else
                    r = longint'(m_chr0 >> 1) * 8192 + low;
            end
            default: r = low;
        endcase
        return r & ((longint'(1) << CHR_AW) - 1);
    endfunction

    function automatic longint exp_ram(input logic [15:0] a);
        return longint'((a >= 16'h6000) && (a < 16'h8000)
                        && (mapper_id != 2'd3 || (m_prg & 16) == 0));
    endfunction

    function automatic longint exp_a10(input logic [13:0] ch);
        if (mapper_id != 2'd3) return longint'(mirror_v ? ch[10] : ch[11]);
        case (m_ctrl & 3)
            0:       return 0;
            1:       return 1;
            2:       return longint'(ch[10]);
            default: return longint'(ch[11]);
        endcase
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            if (prga[15]) check("prg_address", longint'(prg_address), exp_prg(prga));
            check("chr_address", longint'(chr_address), exp_chr(chra));
            check("prg_ram_sel", longint'(prg_ram_sel), exp_ram(prga));
            check("vram_a10", longint'(vram_a10), exp_a10(chra));
        end
    end

    task automatic cyc(input bit c, input bit w, input logic [15:0] a, input logic [7:0] d);
        ce = c; prgw = w; prga = a; prgd = d;
        chra = 14'(n_cyc * 1187);
        n_cyc++;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d);
        cyc(1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic mmc_load(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr(a, {1'b0, 6'h2A, v[i]});
    endtask

    // Write, a ce=0 cycle still strobing, then a second write that must be filtered out.
    task automatic mmc_pair(input logic [15:0] a, input logic b);
        cyc(1'b1, 1'b1, a, {1'b0, 6'h15, b});
        cyc(1'b0, 1'b1, a, {1'b0, 6'h15, ~b});
        cyc(1'b1, 1'b1, a, {1'b0, 6'h15, ~b});
        cyc(1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic peek(input logic [15:0] a, input logic [13:0] ch);
        ce = 1'b0; prgw = 1'b0; prga = a; chra = ch;
        #1;
    endtask

    task automatic do_reset(input logic [1:0] id);
        ce = 1'b0; prgw = 1'b0; reset_n = 1'b0; mapper_id = id;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        ce = 1'b0; prgw = 1'b0; prga = 16'h8000; prgd = 8'h00; chra = 14'h0;
        prg_size = 1'b0; mirror_v = 1'b1; mapper_id = 2'd3; reset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // MMC1 reset state: $8000 bank 0, $C000 fixed to last bank
        do_reset(2'd3);
        peek(16'hFFFC, 14'h0000);
        check("lit_reset_fffc", longint'(prg_address), 'h1FFFC);
        peek(16'h8000, 14'h0000);
        check("lit_reset_8000", longint'(prg_address), 'h00000);
        cyc(1'b0, 1'b0, 16'hC000, 8'h00);

        // Serial load prg=5 with spaced writes
        mmc_load(16'hE000, 5'b00101);
        peek(16'h8123, 14'h0000);
        check("lit_mmc1_prg5", longint'(prg_address), 'h14123);
        peek(16'h6000, 14'h0000);
        check("lit_ram_sel_on", longint'(prg_ram_sel), 1);

        // Consecutive-write filter: only the first write of each burst counts
        mmc_pair(16'hE000, 1'b1);
        mmc_pair(16'hE000, 1'b1);
        mmc_pair(16'hE000, 1'b0);
        mmc_pair(16'hE000, 1'b0);
        mmc_pair(16'hE000, 1'b1);
        peek(16'h8123, 14'h0000);
        check("lit_filter_prg", longint'(prg_address), 'h0C123);
        peek(16'h6000, 14'h0000);
        check("lit_ram_sel_off", longint'(prg_ram_sel), 0);

        // Abort a partial load with bit 7, then load control=2
        wr(16'h8000, 8'h01);
        wr(16'h8000, 8'h01);
        wr(16'h8000, 8'h80);
        mmc_load(16'h8000, 5'd2);
        peek(16'h8123, 14'h0400);
        check("lit_mmc1_32k", longint'(prg_address), 'h08123);
        check("lit_a10_v1", longint'(vram_a10), 1);
        peek(16'h8123, 14'h0800);
        check("lit_a10_v0", longint'(vram_a10), 0);

        // CHR banking, 8K then 4K mode
        mmc_load(16'hA000, 5'd5);
        peek(16'h8000, 14'h0123);
        check("lit_chr8k", longint'(chr_address), 'h4123);
        mmc_load(16'h8000, 5'h13);
        mmc_load(16'hC000, 5'h1F);
        peek(16'h8000, 14'h1123);
        check("lit_chr4k_hi", longint'(chr_address), 'hF123);
        peek(16'h8000, 14'h0923);
        check("lit_chr4k_lo", longint'(chr_address), 'h5923);
        check("lit_a10_h", longint'(vram_a10), 1);

        // Reset in the middle of a serial load clears everything at once
        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h01);
        ce = 1'b0; prgw = 1'b0; reset_n = 1'b0;
        model_reset();
        peek(16'hFFFC, 14'h1123);
        check("lit_async_prg", longint'(prg_address), 'h1FFFC);
        check("lit_async_chr", longint'(chr_address), 'h1123);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mmc_load(16'hE000, 5'd2);
        peek(16'h8123, 14'h0000);
        check("lit_after_reset", longint'(prg_address), 'h08123);

        // UxROM
        do_reset(2'd1);
        mirror_v = 1'b1;
        wr(16'h8000, 8'h03);
        peek(16'h8010, 14'h0400);
        check("lit_ux_lo", longint'(prg_address), 'h0C010);
        check("lit_ux_a10", longint'(vram_a10), 1);
        peek(16'hC010, 14'h0000);
        check("lit_ux_hi", longint'(prg_address), 'h1C010);
        wr(16'h8000, 8'h0B);
        peek(16'h8010, 14'h0000);
        check("lit_ux_wrap", longint'(prg_address), 'h0C010);
        cyc(1'b0, 1'b1, 16'h8000, 8'h05);
        cyc(1'b1, 1'b1, 16'h7000, 8'h05);
        cyc(1'b1, 1'b0, 16'h8000, 8'h00);
        peek(16'h8010, 14'h0000);
        check("lit_ux_no_write", longint'(prg_address), 'h0C010);
        mirror_v = 1'b0;
        peek(16'h8010, 14'h0800);
        check("lit_ux_horiz", longint'(vram_a10), 1);
        cyc(1'b0, 1'b0, 16'hC000, 8'h00);

        // CNROM
        do_reset(2'd2);
        wr(16'h9000, 8'h02);
        peek(16'h8123, 14'h0123);
        check("lit_cn_chr", longint'(chr_address), 'h4123);
        check("lit_cn_prg", longint'(prg_address), 'h00123);
        peek(16'h6000, 14'h0000);
        check("lit_cn_ram", longint'(prg_ram_sel), 1);
        cyc(1'b0, 1'b0, 16'h8000, 8'h00);

        // NROM, both PRG sizes; writes have no effect
        do_reset(2'd0);
        prg_size = 1'b0;
        wr(16'h8000, 8'h07);
        peek(16'hC123, 14'h1234);
        check("lit_nrom16", longint'(prg_address), 'h00123);
        check("lit_nrom_chr", longint'(chr_address), 'h1234);
        prg_size = 1'b1;
        peek(16'hC123, 14'h0000);
        check("lit_nrom32", longint'(prg_address), 'h04123);
        cyc(1'b0, 1'b0, 16'hC000, 8'h00);
        cyc(1'b0, 1'b0, 16'h8000, 8'h00);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
